// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
// Drain stage that sits directly behind sync_fifo. It pops words from the FIFO read
// port and presents them on a valid/ready stream. A 2-entry skid buffer covers the
// FIFO's one-cycle read latency, so the stream can deliver one word per clock without
// dropping or duplicating data. A wrapping counter tracks the number of delivered words.
module fifo_stream_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   // Skid buffer storage and bookkeeping registers
   logic [DATA_WIDTH-1:0] buf_r [0:1];
   logic                  head_r;      // index of the oldest buffered word
   logic [1:0]            occ_r;       // number of buffered words, 0..2
   logic                  inflight_r;  // a read was issued last cycle
   logic [CNT_WIDTH-1:0]  word_cnt_r;

   // Combinational helpers
   logic                  pop_s;
   logic [1:0]            level_s;     // buffered plus in-flight words
   logic                  room_s;
   logic                  rd_en_s;
   logic                  wr_idx_s;    // tail slot written by a capture
   logic [1:0]            occ_nxt_s;

   // Read issue, pop detection and next occupancy
   always_comb begin
      pop_s     = 1'b0;
      level_s   = 2'd0;
      room_s    = 1'b0;
      rd_en_s   = 1'b0;
      wr_idx_s  = 1'b0;
      occ_nxt_s = 2'd0;

      pop_s   = (occ_r != 2'd0) & m_ready;
      level_s = occ_r + {1'b0, inflight_r};
      room_s  = (level_s < 2'd2);

      // A pop this cycle frees a slot, so a read may be issued even when full.
      // Reads are suppressed while reset is applied so nothing is requested then.
      if (rst) begin
         rd_en_s = 1'b0;
      end else begin
         rd_en_s = en & ~fifo_empty & (room_s | pop_s);
      end

      // Tail = head + occ (mod 2). With occ=2 and a simultaneous pop this lands on
      // the slot being vacated, which is also the tail after the head advances.
      wr_idx_s  = head_r ^ occ_r[0];
      occ_nxt_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
   end

   // Buffer, pointers, in-flight flag and delivered-word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r[0]   <= {DATA_WIDTH{1'b0}};
         buf_r[1]   <= {DATA_WIDTH{1'b0}};
         head_r     <= 1'b0;
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         word_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         inflight_r <= rd_en_s;
         occ_r      <= occ_nxt_s;
         if (pop_s) begin
            head_r     <= ~head_r;
            word_cnt_r <= word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            head_r     <= head_r;
            word_cnt_r <= word_cnt_r;
         end
         if (inflight_r) begin
            buf_r[wr_idx_s] <= fifo_data_out;
         end else begin
            buf_r[wr_idx_s] <= buf_r[wr_idx_s];
         end
      end
   end

   // Outputs are taken straight from registered state (rd_en and cs excepted)
   always_comb begin
      fifo_cs    = en;
      fifo_rd_en = rd_en_s;
      m_valid    = (occ_r != 2'd0);
      m_data     = buf_r[head_r];
      word_cnt   = word_cnt_r;
   end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed self-checking bench for fifo_stream_drain. A small queue models sync_fifo:
// a read strobe seen at a rising edge returns the front word on the following cycle.
module tb_fifo_stream_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        fifo_empty;
   logic [31:0] fifo_data_out;
   logic        fifo_cs;
   logic        fifo_rd_en;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;
   logic [15:0] word_cnt;

   // second instance with a 2-bit counter for the wrap check
   logic        rst2;
   logic        en2;
   logic        fifo_empty2;
   logic [7:0]  fifo_data_out2;
   logic        fifo_cs2;
   logic        fifo_rd_en2;
   logic        m_valid2;
   logic [7:0]  m_data2;
   logic        m_ready2;
   logic [1:0]  word_cnt2;

   int checks   = 0;
   int failures = 0;

   logic [31:0] fq [$];     // FIFO contents model
   logic [31:0] got [$];    // accepted stream words
   int          pop_cyc [$];
   int          rd_cyc [$];
   int          cyc = 0;
   int          rd_cnt = 0;
   int          viol = 0;

   always #5 clk = ~clk;

   fifo_stream_drain #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .word_cnt(word_cnt)
   );

   fifo_stream_drain #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .fifo_empty(fifo_empty2),
      .fifo_data_out(fifo_data_out2), .fifo_cs(fifo_cs2), .fifo_rd_en(fifo_rd_en2),
      .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2), .word_cnt(word_cnt2)
   );

   // stream and read-strobe monitor
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst && m_valid && m_ready) begin
         got.push_back(m_data);
         pop_cyc.push_back(cyc);
      end
      if (fifo_rd_en) begin
         rd_cnt = rd_cnt + 1;
         rd_cyc.push_back(cyc);
         if (fifo_empty) viol = viol + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // words got[base..base+n-1] must be first, first+step, ...
   task automatic check_seq(input string tag, input int base, input int n,
                            input int first, input int step);
      logic [31:0] v;
      check({tag, "_count"}, got.size() - base, n);
      for (int i = 0; i < n; i++) begin
         v = (base + i < got.size()) ? got[base + i] : 32'hDEADBEEF;
         check($sformatf("%s_w%0d", tag, i), v, first + i * step);
      end
   endtask

   task automatic push(input logic [31:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // advance n cycles; FIFO model returns a word one cycle after a sampled read strobe
   task automatic tick(input int n);
      logic rd;
      for (int k = 0; k < n; k++) begin
         #1;
         rd = fifo_rd_en;
         @(posedge clk);
         @(negedge clk);
         if (rd === 1'b1 && fq.size() > 0) begin
            fifo_data_out = fq.pop_front();
            fifo_empty    = (fq.size() == 0);
         end
      end
   endtask

   task automatic settle;
      #1;
   endtask

   int base;
   int rbase;

   initial begin
      // ---------- 1. reset with FIFO non-empty ----------
      rst = 1'b1; en = 1'b1; m_ready = 1'b1;
      fifo_empty = 1'b1; fifo_data_out = 32'd0;
      rst2 = 1'b1; en2 = 1'b0; fifo_empty2 = 1'b0; fifo_data_out2 = 8'h5A; m_ready2 = 1'b1;
      push(32'd7); push(32'd8); push(32'd9);
      tick(2); settle;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_cs", fifo_cs, 1);
      fq.delete(); fifo_empty = 1'b1; rst = 1'b0;
      tick(1); settle;

      // ---------- 2. basic drain 100,200,300 ----------
      base = got.size();
      push(32'd100); push(32'd200); push(32'd300); settle;
      check("basic_rd_c0", fifo_rd_en, 1);
      check("basic_valid_c0", m_valid, 0);
      tick(1); settle;
      check("basic_valid_c1", m_valid, 0);
      tick(1); settle;
      check("basic_valid_c2", m_valid, 1);
      check("basic_data_c2", m_data, 100);
      tick(1); settle;
      check("basic_data_c3", m_data, 200);
      check("basic_rd_after_empty", fifo_rd_en, 0);
      tick(1); settle;
      check("basic_data_c4", m_data, 300);
      tick(1); settle;
      check("basic_valid_end", m_valid, 0);
      check("basic_word_cnt", word_cnt, 3);
      check_seq("basic", base, 3, 100, 100);

      // ---------- 3. full rate 1..8 ----------
      base = got.size(); rbase = rd_cyc.size();
      for (int i = 1; i <= 8; i++) push(i);
      tick(12); settle;
      check_seq("rate", base, 8, 1, 1);
      check("rate_rd_count", rd_cyc.size() - rbase, 8);
      if (rd_cyc.size() - rbase == 8)
         check("rate_rd_span", rd_cyc[rbase + 7] - rd_cyc[rbase], 7);
      if (pop_cyc.size() - base == 8)
         check("rate_pop_span", pop_cyc[base + 7] - pop_cyc[base], 7);
      check("rate_word_cnt", word_cnt, 11);

      // ---------- 4. backpressure ----------
      base = got.size(); rbase = rd_cnt;
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(i);
      tick(5); settle;
      check("bp_rd_pulses", rd_cnt - rbase, 2);
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 1);
      check("bp_rd_en", fifo_rd_en, 0);
      tick(3); settle;
      check("bp_data_hold", m_data, 1);
      check("bp_rd_pulses_hold", rd_cnt - rbase, 2);
      m_ready = 1'b1;
      tick(14); settle;
      check_seq("bp", base, 8, 1, 1);
      check("bp_word_cnt", word_cnt, 19);
      check("bp_valid_end", m_valid, 0);

      // ---------- 5. en toggle ----------
      base = got.size(); rbase = rd_cnt;
      for (int i = 1; i <= 8; i++) push(i);
      tick(3);
      en = 1'b0; settle;
      check("en_rd_pulses", rd_cnt - rbase, 3);
      check("en_rd_en_low", fifo_rd_en, 0);
      check("en_cs_low", fifo_cs, 0);
      tick(6); settle;
      check_seq("en_off", base, 3, 1, 1);
      check("en_rd_hold", rd_cnt - rbase, 3);
      check("en_valid_drained", m_valid, 0);
      en = 1'b1;
      tick(12); settle;
      check_seq("en_on", base, 8, 1, 1);
      check("en_rd_total", rd_cnt - rbase, 8);
      check("en_word_cnt", word_cnt, 27);

      // ---------- 6. mid-operation reset ----------
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(i);
      tick(2); settle;
      check("mid_valid_before", m_valid, 1);
      check("mid_data_before", m_data, 1);
      rst = 1'b1;
      tick(1); settle;
      check("mid_valid_after", m_valid, 0);
      check("mid_word_cnt", word_cnt, 0);
      check("mid_data_after", m_data, 0);
      check("mid_rd_en", fifo_rd_en, 0);
      fq.delete(); fifo_empty = 1'b1;
      rst = 1'b0; m_ready = 1'b1;
      base = got.size();
      push(32'd500); push(32'd600);
      tick(8); settle;
      check_seq("mid_fresh", base, 2, 500, 100);
      check("mid_fresh_word_cnt", word_cnt, 2);

      // ---------- word_cnt wrap, CNT_WIDTH=2 ----------
      tick(1);
      rst2 = 1'b0; settle;
      check("wrap_cnt_reset", word_cnt2, 0);
      en2 = 1'b1;
      tick(5);
      en2 = 1'b0;
      tick(6); settle;
      check("wrap_word_cnt", word_cnt2, 1);
      check("wrap_valid_end", m_valid2, 0);

      check("rd_while_empty", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
